cpu_mem_responder: RTL

- Memory-side responder for the CPU's fetch port (instr_read/instr_addr/instr_out) and data port (data_read/data_addr/data_write/data_in/data_out).
- Dual-port word array with byte-lane writes and registered one-cycle read latency; matches the CPU's one-wait-state fetch and load timing with no ready/stall signalling.
- Adds a word-wide loader port for program/data preload from the testbench or boot logic, plus a sticky error capture for out-of-range and misaligned accesses.

---
 rtl/cpu_mem_pkg.sv | 16 +
 rtl/mem_bank_dp.sv | 48 ++++
 rtl/cpu_mem_responder.sv | 118 +++++++++++
 3 files changed

// File: rtl/cpu_mem_pkg.sv
// Shared constants for the CPU memory responder.
// Error codes, default geometry and lane count.
package cpu_mem_pkg;

  localparam int unsigned DEPTH_WORDS = 16384;
  localparam logic [31:0] BASE_ADDR   = 32'h0000_0000;
  localparam int unsigned LANES       = 4;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_I_OOR   = 2'b01,
    ERR_D_OOR   = 2'b10,
    ERR_I_MISAL = 2'b11
  } err_code_e;

endpackage

// File: rtl/mem_bank_dp.sv
// Word array: two registered read-first read ports,
// one byte-enable write port and one full-word write port.
module mem_bank_dp
  import cpu_mem_pkg::*;
#(
  parameter int unsigned DEPTH = 16384,
  parameter int unsigned AW    = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_en,
  input  logic             a_ok,
  input  logic [AW-1:0]    a_idx,
  output logic [31:0]      a_q,
  input  logic             b_en,
  input  logic             b_ok,
  input  logic [AW-1:0]    b_idx,
  output logic [31:0]      b_q,
  input  logic [LANES-1:0] w_be,
  input  logic [AW-1:0]    w_idx,
  input  logic [31:0]      w_data,
  input  logic             l_we,
  input  logic [AW-1:0]    l_idx,
  input  logic [31:0]      l_data
);

  logic [31:0] r_mem [DEPTH];

  // No reset on the array: contents survive rst and
  // the loader may write while rst is high.
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(LANES); i++) begin
      if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_data[8*i +: 8];
    end
    if (l_we) r_mem[l_idx] <= l_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      if (a_en) a_q <= a_ok ? r_mem[a_idx] : 32'h0;
      if (b_en) b_q <= b_ok ? r_mem[b_idx] : 32'h0;
    end
  end

endmodule

// File: rtl/cpu_mem_responder.sv
// Memory responder for the CPU fetch and data ports,
// with a word loader and sticky access-error capture.
module cpu_mem_responder
  import cpu_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = cpu_mem_pkg::DEPTH_WORDS,
  parameter int unsigned ADDR_W      = 14,
  parameter logic [31:0] BASE_ADDR   = cpu_mem_pkg::BASE_ADDR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_read,
  input  logic [31:0]       instr_addr,
  output logic [31:0]       instr_out,
  input  logic              data_read,
  input  logic [31:0]       data_addr,
  input  logic [LANES-1:0]  data_write,
  input  logic [31:0]       data_in,
  output logic [31:0]       data_out,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [31:0]       ld_data,
  input  logic              err_clr,
  output logic              err_valid,
  output logic [1:0]        err_code,
  output logic [31:0]       err_addr
);

  localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) * 33'd4;

  logic [31:0]       w_i_off;
  logic [31:0]       w_d_off;
  logic              w_i_inr;
  logic              w_d_inr;
  logic [ADDR_W-1:0] w_i_idx;
  logic [ADDR_W-1:0] w_d_idx;
  logic [LANES-1:0]  w_d_be;
  logic              w_i_err;
  logic              w_d_err;
  logic              w_any_err;
  logic [1:0]        w_new_code;
  logic [31:0]       w_new_addr;

  assign w_i_off = instr_addr - BASE_ADDR;
  assign w_d_off = data_addr - BASE_ADDR;
  assign w_i_inr = (instr_addr >= BASE_ADDR) && ({1'b0, w_i_off} < SPAN);
  assign w_d_inr = (data_addr >= BASE_ADDR) && ({1'b0, w_d_off} < SPAN);
  assign w_i_idx = w_i_off[ADDR_W+1:2];
  assign w_d_idx = w_d_off[ADDR_W+1:2];

  // Loader owns the word outright when both target it.
  assign w_d_be = (w_d_inr && !(ld_we && ld_addr == w_d_idx))
                ? data_write : '0;

  assign w_i_err = instr_read && (!w_i_inr || instr_addr[1:0] != 2'b00);
  assign w_d_err = (data_read || data_write != '0) && !w_d_inr;
  assign w_any_err = w_i_err || w_d_err;

  always_comb begin
    w_new_code = ERR_NONE;
    w_new_addr = '0;
    unique case (1'b1)
      (w_i_err && !w_i_inr): begin
        w_new_code = ERR_I_OOR;
        w_new_addr = instr_addr;
      end
      (w_i_err && w_i_inr): begin
        w_new_code = ERR_I_MISAL;
        w_new_addr = instr_addr;
      end
      (!w_i_err && w_d_err): begin
        w_new_code = ERR_D_OOR;
        w_new_addr = data_addr;
      end
      default: ;
    endcase
  end

  // A fresh error in the clear cycle is kept, not lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_valid <= 1'b0;
      err_code  <= ERR_NONE;
      err_addr  <= '0;
    end else if (w_any_err && (!err_valid || err_clr)) begin
      err_valid <= 1'b1;
      err_code  <= w_new_code;
      err_addr  <= w_new_addr;
    end else if (err_clr) begin
      err_valid <= 1'b0;
      err_code  <= ERR_NONE;
      err_addr  <= '0;
    end
  end

  mem_bank_dp #(
    .DEPTH (DEPTH_WORDS),
    .AW    (ADDR_W)
  ) u_bank (
    .clk    (clk),
    .rst    (rst),
    .a_en   (instr_read),
    .a_ok   (w_i_inr),
    .a_idx  (w_i_idx),
    .a_q    (instr_out),
    .b_en   (data_read),
    .b_ok   (w_d_inr),
    .b_idx  (w_d_idx),
    .b_q    (data_out),
    .w_be   (w_d_be),
    .w_idx  (w_d_idx),
    .w_data (data_in),
    .l_we   (ld_we),
    .l_idx  (ld_addr),
    .l_data (ld_data)
  );

endmodule
